// File: rtl/pipe_pal_sched.sv
// Round-robin scheduler sharing one add/accumulate datapath among N_REQ requesters, with
// per-requester in-flight tracking, tagged response routing and a pause/drain quiesce sequence.
module pipe_pal_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned MAX_OUT = 3,
  localparam int unsigned W_ID   = $clog2(N_REQ),
  localparam int unsigned W_CNT  = $clog2(MAX_OUT + 1)
) (
  input  logic                      i_clk,
  input  logic                      resetn,
  input  logic                      i_pause,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*W_DATA-1:0]   i_req_a,
  input  logic [N_REQ*W_DATA-1:0]   i_req_b,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_op_valid,
  output logic [W_DATA-1:0]         o_op_a,
  output logic [W_DATA-1:0]         o_op_b,
  output logic [W_ID-1:0]           o_op_id,
  input  logic                      i_op_ready,
  input  logic                      i_rsp_valid,
  input  logic [W_ID-1:0]           i_rsp_id,
  input  logic [W_DATA-1:0]         i_rsp_data,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [W_DATA-1:0]         o_rsp_data,
  output logic [1:0]                o_state,
  output logic                      o_idle,
  output logic                      o_err
);

  typedef enum logic [1:0] {StRun = 2'd0, StDrain = 2'd1, StPaused = 2'd2} state_e;

  state_e              state_q;
  logic [W_ID-1:0]     rr_ptr_q;
  logic [W_CNT-1:0]    cnt_q [N_REQ];
  logic                op_valid_q;
  logic [W_DATA-1:0]   op_a_q;
  logic [W_DATA-1:0]   op_b_q;
  logic [W_ID-1:0]     op_id_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [W_DATA-1:0]   rsp_data_q;
  logic                err_q;

  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    grant;
  logic                any_grant;
  logic [W_ID-1:0]     winner;
  logic                cnt_zero;
  logic                rsp_in_range;
  logic                rsp_hit;
  logic                rsp_bad;

  // Tags can only be out of range when N_REQ is not a power of two.
  if (N_REQ == (1 << W_ID)) begin : g_full_range
    assign rsp_in_range = 1'b1;
  end else begin : g_part_range
    assign rsp_in_range = (i_rsp_id < W_ID'(N_REQ));
  end

  assign rsp_hit = i_rsp_valid && rsp_in_range;
  assign rsp_bad = i_rsp_valid && (!rsp_in_range || (cnt_q[i_rsp_id] == '0));

  always_comb begin
    cnt_zero = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = i_req_valid[i] && (cnt_q[i] < W_CNT'(MAX_OUT));
      if (cnt_q[i] != '0) cnt_zero = 1'b0;
    end
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    any_grant = 1'b0;
    winner    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!any_grant && eligible[idx]) begin
        any_grant = 1'b1;
        winner    = W_ID'(idx);
      end
    end
    // The slot may refill in the same cycle the datapath takes the current op.
    any_grant = any_grant && (state_q == StRun) && (!op_valid_q || i_op_ready);
    grant     = '0;
    if (any_grant) grant[winner] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!resetn) begin
      state_q     <= StRun;
      rr_ptr_q    <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      unique case (state_q)
        StRun:    if (i_pause) state_q <= StDrain;
        StDrain: begin
          if (!i_pause)                     state_q <= StRun;
          else if (!op_valid_q && cnt_zero) state_q <= StPaused;
        end
        StPaused: if (!i_pause) state_q <= StRun;
        default:  state_q <= StRun;
      endcase

      if (any_grant) begin
        op_valid_q <= 1'b1;
        op_a_q     <= i_req_a[int'(winner)*W_DATA +: W_DATA];
        op_b_q     <= i_req_b[int'(winner)*W_DATA +: W_DATA];
        op_id_q    <= winner;
        rr_ptr_q   <= (winner == W_ID'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end else if (i_op_ready) begin
        op_valid_q <= 1'b0;
      end

      // A response against a zero counter is flagged and never underflows.
      for (int i = 0; i < N_REQ; i++) begin
        logic dec;
        dec = rsp_hit && (i_rsp_id == W_ID'(i)) && (cnt_q[i] != '0);
        if (grant[i] && !dec)      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec && !grant[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end

      rsp_valid_q <= '0;
      if (rsp_hit) rsp_valid_q[i_rsp_id] <= 1'b1;
      if (i_rsp_valid) rsp_data_q <= i_rsp_data;
      if (rsp_bad) err_q <= 1'b1;
    end
  end

  assign o_req_ready = grant;
  assign o_op_valid  = op_valid_q;
  assign o_op_a      = op_a_q;
  assign o_op_b      = op_b_q;
  assign o_op_id     = op_id_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_state     = state_q;
  assign o_idle      = !op_valid_q && cnt_zero;
  assign o_err       = err_q;

endmodule

// File: tb/tb_pipe_pal_sched.sv
// Directed bench for pipe_pal_sched: the bench plays requesters and datapath, keeping
// scoreboard queues of expected issued ops and expected response strobes.
module tb_pipe_pal_sched;

  logic         clk;
  logic         resetn;
  logic         i_pause;
  logic [3:0]   i_req_valid;
  logic [127:0] i_req_a;
  logic [127:0] i_req_b;
  logic [3:0]   o_req_ready;
  logic         o_op_valid;
  logic [31:0]  o_op_a;
  logic [31:0]  o_op_b;
  logic [1:0]   o_op_id;
  logic         i_op_ready;
  logic         i_rsp_valid;
  logic [1:0]   i_rsp_id;
  logic [31:0]  i_rsp_data;
  logic [3:0]   o_rsp_valid;
  logic [31:0]  o_rsp_data;
  logic [1:0]   o_state;
  logic         o_idle;
  logic         o_err;

  pipe_pal_sched dut (
    .i_clk       (clk),
    .resetn      (resetn),
    .i_pause     (i_pause),
    .i_req_valid (i_req_valid),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_req_ready (o_req_ready),
    .o_op_valid  (o_op_valid),
    .o_op_a      (o_op_a),
    .o_op_b      (o_op_b),
    .o_op_id     (o_op_id),
    .i_op_ready  (i_op_ready),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_id    (i_rsp_id),
    .i_rsp_data  (i_rsp_data),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_state     (o_state),
    .o_idle      (o_idle),
    .o_err       (o_err)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    logic        v;
    logic [1:0]  id;
    logic [31:0] d;
  } rsp_t;

  op_t         op_q[$];
  rsp_t        rsp_q[$];
  rsp_t        hold_q[$];
  rsp_t        s1, s2, man;
  logic [31:0] a_val [4];
  logic [31:0] b_val [4];
  bit          auto_rsp;
  logic        exp_err;
  logic [1:0]  exp_state;
  int          n_checks;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      i_req_a[i*32 +: 32] = a_val[i];
      i_req_b[i*32 +: 32] = b_val[i];
    end
  endtask

  task automatic respond_held();
    man = hold_q.pop_front();
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic [3:0] exp_rdy);
    rsp_t drv, nw, r;
    op_t  o;
    int   gi;
    drv = auto_rsp ? s2 : man;
    man.v = 1'b0;
    i_rsp_valid = drv.v;
    i_rsp_id    = drv.id;
    i_rsp_data  = drv.d;
    #1;
    chk("op_valid", o_op_valid, op_q.size() != 0);
    nw = '{v: 1'b0, id: 2'd0, d: 32'd0};
    if (op_q.size() > 0) begin
      o = op_q[0];
      chk("op_id", o_op_id, o.id);
      chk("op_a", o_op_a, o.a);
      chk("op_b", o_op_b, o.b);
      if (i_op_ready) begin
        void'(op_q.pop_front());
        nw = '{v: 1'b1, id: o.id, d: o.a + o.b};
      end
    end
    chk("req_ready", o_req_ready, exp_rdy);
    gi = -1;
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) gi = i;
    if (gi >= 0) op_q.push_back('{id: 2'(gi), a: a_val[gi], b: b_val[gi]});
    if (auto_rsp) begin
      s2 = s1;
      s1 = nw;
    end else if (nw.v) begin
      hold_q.push_back(nw);
    end
    if (drv.v) rsp_q.push_back(drv);
    @(posedge clk);
    #1;
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      chk("rsp_valid", o_rsp_valid, 4'b0001 << r.id);
      chk("rsp_data", o_rsp_data, r.d);
    end else begin
      chk("rsp_idle", o_rsp_valid, 4'b0000);
    end
    chk("state", o_state, exp_state);
    chk("err", o_err, exp_err);
    if (gi >= 0) begin
      a_val[gi] = $urandom;
      b_val[gi] = $urandom;
      drive_ops();
    end
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    man.v       = 1'b0;
    i_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    op_q.delete();
    rsp_q.delete();
    hold_q.delete();
    s1.v      = 1'b0;
    s2.v      = 1'b0;
    exp_err   = 1'b0;
    exp_state = 2'd0;
    #1;
    chk("rst_op_valid", o_op_valid, 1'b0);
    chk("rst_op_a", o_op_a, 32'd0);
    chk("rst_op_b", o_op_b, 32'd0);
    chk("rst_op_id", o_op_id, 2'd0);
    chk("rst_rsp_valid", o_rsp_valid, 4'd0);
    chk("rst_rsp_data", o_rsp_data, 32'd0);
    chk("rst_state", o_state, 2'd0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_idle", o_idle, 1'b1);
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    resetn      = 1'b0;
    i_pause     = 1'b0;
    i_req_valid = 4'b0000;
    i_op_ready  = 1'b1;
    i_rsp_valid = 1'b0;
    i_rsp_id    = 2'd0;
    i_rsp_data  = 32'd0;
    man         = '{v: 1'b0, id: 2'd0, d: 32'd0};
    s1          = man;
    s2          = man;
    auto_rsp    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_val[i] = $urandom;
      b_val[i] = $urandom;
    end
    drive_ops();
    do_reset();
    chk("rst_ready", o_req_ready, 4'b0000);

    // All requesters busy: strict rotation, responses two cycles after issue.
    i_req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) cyc(4'b0001 << (k % 4));
    i_req_valid = 4'b0000;
    repeat (5) cyc(4'b0000);
    chk("t1_idle", o_idle, 1'b1);

    // Requester 1 alone with responses withheld saturates at three in flight.
    auto_rsp    = 1'b0;
    i_req_valid = 4'b0010;
    repeat (3) cyc(4'b0010);
    repeat (2) cyc(4'b0000);
    respond_held();
    cyc(4'b0000);
    cyc(4'b0010);
    cyc(4'b0000);
    i_req_valid = 4'b0000;
    repeat (3) begin
      respond_held();
      cyc(4'b0000);
    end
    cyc(4'b0000);
    chk("t2_idle", o_idle, 1'b1);

    // Back-pressured slot holds steady, then refills in the cycle it drains.
    auto_rsp    = 1'b1;
    i_req_valid = 4'b0001;
    i_op_ready  = 1'b0;
    cyc(4'b0001);
    repeat (5) cyc(4'b0000);
    i_op_ready = 1'b1;
    cyc(4'b0001);
    i_req_valid = 4'b0000;
    repeat (5) cyc(4'b0000);

    // Simultaneous grant and response to requester 2, then a stray response.
    auto_rsp    = 1'b0;
    i_req_valid = 4'b0100;
    cyc(4'b0100);
    cyc(4'b0100);
    respond_held();
    cyc(4'b0100);
    cyc(4'b0100);
    cyc(4'b0000);
    i_req_valid = 4'b0000;
    repeat (3) begin
      respond_held();
      cyc(4'b0000);
    end
    man     = '{v: 1'b1, id: 2'd2, d: 32'hDEAD_BEEF};
    exp_err = 1'b1;
    cyc(4'b0000);
    repeat (2) cyc(4'b0000);

    // Pause raised alongside a grant: drain two ops, park, then resume.
    i_req_valid = 4'b0001;
    cyc(4'b0001);
    i_pause   = 1'b1;
    exp_state = 2'd1;
    cyc(4'b0001);
    cyc(4'b0000);
    respond_held();
    cyc(4'b0000);
    chk("t5_busy", o_idle, 1'b0);
    respond_held();
    cyc(4'b0000);
    exp_state = 2'd2;
    cyc(4'b0000);
    chk("t5_paused_idle", o_idle, 1'b1);
    i_pause   = 1'b0;
    exp_state = 2'd0;
    cyc(4'b0000);
    cyc(4'b0001);
    i_req_valid = 4'b0000;
    cyc(4'b0000);
    respond_held();
    cyc(4'b0000);
    cyc(4'b0000);

    // Reset mid-burst drops in-flight work and restarts arbitration at 0.
    auto_rsp    = 1'b1;
    i_req_valid = 4'b1111;
    cyc(4'b0010);
    cyc(4'b0100);
    cyc(4'b1000);
    do_reset();
    for (int k = 0; k < 4; k++) cyc(4'b0001 << k);
    i_req_valid = 4'b0000;
    repeat (5) cyc(4'b0000);
    chk("t6_idle", o_idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
